gpio_pulse_driver: RTL and testbench

//  Output-side counterpart of the GPIO input debouncer. It drives NUM_PINS GPIO output pins

---
 rtl/gpio_pulse_driver.sv | 152 +++++++++++++++
 tb/tb_gpio_pulse_driver.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pulse_driver.sv
// GPIO output pulse driver: drives NUM_PINS pad outputs from a single valid/ready
// command port supporting static levels, toggle and timed pulses per pin.
module gpio_pulse_driver #(
  parameter int                  NUM_PINS  = 16,
  parameter int                  PULSE_W   = 16,
  parameter logic [NUM_PINS-1:0] RESET_VAL = '0,
  localparam int                 PIN_W     = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [PIN_W-1:0]    cmd_pin,
  input  logic [1:0]          cmd_op,
  input  logic [PULSE_W-1:0]  cmd_len,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] busy,
  output logic [NUM_PINS-1:0] done,
  output logic                cmd_err
);

  typedef enum logic [1:0] {
    OP_SET_LOW  = 2'd0,
    OP_SET_HIGH = 2'd1,
    OP_TOGGLE   = 2'd2,
    OP_PULSE    = 2'd3
  } op_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PULSING = 1'b1
  } pin_state_t;

  pin_state_t           state_q [NUM_PINS];
  pin_state_t           state_d [NUM_PINS];
  logic [PULSE_W-1:0]   cnt_q   [NUM_PINS];
  logic [PULSE_W-1:0]   cnt_d   [NUM_PINS];
  logic [NUM_PINS-1:0]  base_q, base_d;
  logic [NUM_PINS-1:0]  out_q, out_d;
  logic [NUM_PINS-1:0]  done_q, done_d;
  logic                 err_q, err_d;

  op_t                  op;
  logic [PIN_W:0]       pin_ext;
  logic                 in_range;
  logic [NUM_PINS-1:0]  pin_sel;
  logic                 accept;
  logic [PULSE_W-1:0]   pulse_cnt;

  assign op       = op_t'(cmd_op);
  // Widen the pin index so an index equal to NUM_PINS is still representable.
  assign pin_ext  = {1'b0, cmd_pin};
  assign in_range = pin_ext < (PIN_W + 1)'(NUM_PINS);

  always_comb begin
    pin_sel = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      pin_sel[i] = in_range && (cmd_pin == PIN_W'(i));
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      busy[i] = (state_q[i] == PULSING);
    end
  end

  // Only a PULSE aimed at a pin that is already pulsing has to wait.
  assign cmd_ready = !((op == OP_PULSE) && (|(pin_sel & busy)));
  assign accept    = cmd_valid && cmd_ready;
  assign pulse_cnt = (cmd_len == '0) ? '0 : cmd_len - PULSE_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    out_d   = out_q;
    done_d  = '0;
    err_d   = accept && !in_range;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (state_q[i] == PULSING) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - PULSE_W'(1);
        end else begin
          out_d[i]   = base_q[i];
          state_d[i] = IDLE;
          done_d[i]  = 1'b1;
        end
      end
      // A command to this pin overrides any expiry computed above.
      if (accept && pin_sel[i]) begin
        case (op)
          OP_SET_LOW: begin
            base_d[i]  = 1'b0;
            out_d[i]   = 1'b0;
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            done_d[i]  = 1'b0;
          end
          OP_SET_HIGH: begin
            base_d[i]  = 1'b1;
            out_d[i]   = 1'b1;
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            done_d[i]  = 1'b0;
          end
          OP_TOGGLE: begin
            base_d[i]  = ~base_q[i];
            out_d[i]   = ~base_q[i];
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            done_d[i]  = 1'b0;
          end
          default: begin
            out_d[i]   = ~base_q[i];
            cnt_d[i]   = pulse_cnt;
            state_d[i] = PULSING;
            done_d[i]  = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PINS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      base_q <= RESET_VAL;
      out_q  <= RESET_VAL;
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PINS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      base_q <= base_d;
      out_q  <= out_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign gpio_out = out_q;
  assign done     = done_q;
  assign cmd_err  = err_q;

endmodule

// File: tb/tb_gpio_pulse_driver.sv
// Directed testbench for gpio_pulse_driver; a second 12-pin instance provides
// encodable out-of-range pin indices.
module tb_gpio_pulse_driver;

  logic        clk;
  logic        reset_n;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_pin;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_len;
  logic [15:0] gpio_out;
  logic [15:0] busy;
  logic [15:0] done;
  logic        cmd_err;

  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_pin;
  logic [1:0]  s_op;
  logic [15:0] s_len;
  logic [11:0] s_gpio;
  logic [11:0] s_busy;
  logic [11:0] s_done;
  logic        s_err;

  int checks;
  int errors;

  localparam logic [1:0] SET_LOW  = 2'd0;
  localparam logic [1:0] SET_HIGH = 2'd1;
  localparam logic [1:0] TOGGLE   = 2'd2;
  localparam logic [1:0] PULSE    = 2'd3;

  gpio_pulse_driver #(
    .NUM_PINS (16),
    .PULSE_W  (16),
    .RESET_VAL(16'h0005)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_pin  (cmd_pin),
    .cmd_op   (cmd_op),
    .cmd_len  (cmd_len),
    .gpio_out (gpio_out),
    .busy     (busy),
    .done     (done),
    .cmd_err  (cmd_err)
  );

  gpio_pulse_driver #(
    .NUM_PINS (12),
    .PULSE_W  (16),
    .RESET_VAL(12'h005)
  ) dut_s (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_valid(s_valid),
    .cmd_ready(s_ready),
    .cmd_pin  (s_pin),
    .cmd_op   (s_op),
    .cmd_len  (s_len),
    .gpio_out (s_gpio),
    .busy     (s_busy),
    .done     (s_done),
    .cmd_err  (s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command for one edge; reports cmd_ready as seen just before that edge.
  task automatic issue(input int pin, input logic [1:0] op, input int len, output logic rdy);
    cmd_valid = 1'b1;
    cmd_pin   = 4'(pin);
    cmd_op    = op;
    cmd_len   = 16'(len);
    #1;
    rdy = cmd_ready;
    step();
    cmd_valid = 1'b0;
    cmd_pin   = 4'd0;
    cmd_op    = SET_LOW;
    cmd_len   = 16'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if (gpio_out !== 16'h0005) begin errors++; $display("[TB] FAIL reset_gpio: got %h expected %h", gpio_out, 16'h0005); end
    checks++;
    if (busy !== 16'h0000) begin errors++; $display("[TB] FAIL reset_busy: got %h expected %h", busy, 16'h0000); end
    checks++;
    if (done !== 16'h0000) begin errors++; $display("[TB] FAIL reset_done: got %h expected %h", done, 16'h0000); end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready); end
    checks++;
    if (cmd_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", cmd_err); end
    checks++;
    if (s_gpio !== 12'h005) begin errors++; $display("[TB] FAIL reset_small_gpio: got %h expected %h", s_gpio, 12'h005); end
  endtask

  task automatic test_pulse();
    logic rdy;
    issue(3, PULSE, 4, rdy);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL pulse_ready: got %b expected 1", rdy); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (gpio_out !== 16'h000D || busy !== 16'h0008 || done !== 16'h0000) begin
        errors++;
        $display("[TB] FAIL pulse_high_c%0d: got gpio=%h busy=%h done=%h expected gpio=000d busy=0008 done=0000", k, gpio_out, busy, done);
      end
      step();
    end
    checks++;
    if (gpio_out !== 16'h0005 || busy !== 16'h0000 || done !== 16'h0008) begin
      errors++;
      $display("[TB] FAIL pulse_end: got gpio=%h busy=%h done=%h expected gpio=0005 busy=0000 done=0008", gpio_out, busy, done);
    end
    step();
    checks++;
    if (done !== 16'h0000) begin errors++; $display("[TB] FAIL pulse_done_strobe: got %h expected %h", done, 16'h0000); end
  endtask

  task automatic test_back_to_back();
    logic rdy;
    int   waited;
    issue(3, PULSE, 10, rdy);
    step();
    step();
    cmd_valid = 1'b1;
    cmd_pin   = 4'd3;
    cmd_op    = PULSE;
    cmd_len   = 16'd2;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_blocked: got %b expected 0", cmd_ready); end
    step();
    issue(5, PULSE, 3, rdy);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_other_pin_ready: got %b expected 1", rdy); end
    checks++;
    if (gpio_out !== 16'h002D || busy !== 16'h0028) begin
      errors++;
      $display("[TB] FAIL b2b_both_busy: got gpio=%h busy=%h expected gpio=002d busy=0028", gpio_out, busy);
    end
    cmd_valid = 1'b1;
    cmd_pin   = 4'd3;
    cmd_op    = PULSE;
    cmd_len   = 16'd2;
    #1;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      step();
      waited++;
    end
    checks++;
    if (waited !== 6) begin errors++; $display("[TB] FAIL b2b_wait_cycles: got %0d expected 6", waited); end
    checks++;
    if (done !== 16'h0008 || gpio_out !== 16'h0005) begin
      errors++;
      $display("[TB] FAIL b2b_first_expiry: got done=%h gpio=%h expected done=0008 gpio=0005", done, gpio_out);
    end
    step();
    cmd_valid = 1'b0;
    cmd_op    = SET_LOW;
    checks++;
    if (busy !== 16'h0008 || gpio_out !== 16'h000D) begin
      errors++;
      $display("[TB] FAIL b2b_second_start: got busy=%h gpio=%h expected busy=0008 gpio=000d", busy, gpio_out);
    end
    step();
    step();
    checks++;
    if (busy !== 16'h0000 || done !== 16'h0008 || gpio_out !== 16'h0005) begin
      errors++;
      $display("[TB] FAIL b2b_second_end: got busy=%h done=%h gpio=%h expected 0000 0008 0005", busy, done, gpio_out);
    end
    step();
  endtask

  task automatic test_set_abort();
    logic rdy;
    int   bad;
    issue(0, SET_LOW, 0, rdy);
    checks++;
    if (gpio_out !== 16'h0004) begin errors++; $display("[TB] FAIL abort_setlow: got %h expected %h", gpio_out, 16'h0004); end
    issue(0, PULSE, 8, rdy);
    checks++;
    if (gpio_out !== 16'h0005 || busy !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL abort_pulse_start: got gpio=%h busy=%h expected 0005 0001", gpio_out, busy);
    end
    step();
    step();
    issue(0, SET_HIGH, 0, rdy);
    checks++;
    if (gpio_out !== 16'h0005 || busy !== 16'h0000 || done !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL abort_sethigh: got gpio=%h busy=%h done=%h expected 0005 0000 0000", gpio_out, busy, done);
    end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (done !== 16'h0000 || gpio_out !== 16'h0005) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d bad cycles expected 0", bad); end
    issue(0, PULSE, 1, rdy);
    checks++;
    if (gpio_out !== 16'h0004 || busy !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL abort_new_base: got gpio=%h busy=%h expected 0004 0001", gpio_out, busy);
    end
    step();
    checks++;
    if (gpio_out !== 16'h0005 || done !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL abort_new_base_end: got gpio=%h done=%h expected 0005 0001", gpio_out, done);
    end
    step();
  endtask

  task automatic test_edge_cases();
    logic rdy;
    issue(7, PULSE, 0, rdy);
    checks++;
    if (gpio_out !== 16'h0085 || busy !== 16'h0080 || done !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL len0_start: got gpio=%h busy=%h done=%h expected 0085 0080 0000", gpio_out, busy, done);
    end
    step();
    checks++;
    if (gpio_out !== 16'h0005 || busy !== 16'h0000 || done !== 16'h0080) begin
      errors++;
      $display("[TB] FAIL len0_end: got gpio=%h busy=%h done=%h expected 0005 0000 0080", gpio_out, busy, done);
    end
    issue(7, TOGGLE, 0, rdy);
    checks++;
    if (gpio_out !== 16'h0085) begin errors++; $display("[TB] FAIL toggle_1: got %h expected %h", gpio_out, 16'h0085); end
    issue(7, TOGGLE, 0, rdy);
    checks++;
    if (gpio_out !== 16'h0005) begin errors++; $display("[TB] FAIL toggle_2: got %h expected %h", gpio_out, 16'h0005); end
    issue(9, PULSE, 2, rdy);
    issue(10, PULSE, 1, rdy);
    checks++;
    if (gpio_out !== 16'h0605 || busy !== 16'h0600) begin
      errors++;
      $display("[TB] FAIL expiry_setup: got gpio=%h busy=%h expected 0605 0600", gpio_out, busy);
    end
    issue(9, SET_LOW, 0, rdy);
    checks++;
    if (gpio_out !== 16'h0005 || busy !== 16'h0000 || done !== 16'h0400) begin
      errors++;
      $display("[TB] FAIL expiry_collision: got gpio=%h busy=%h done=%h expected 0005 0000 0400", gpio_out, busy, done);
    end
    step();
  endtask

  task automatic test_out_of_range();
    s_valid = 1'b1;
    s_pin   = 4'd12;
    s_op    = PULSE;
    s_len   = 16'd3;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL oor_ready: got %b expected 1", s_ready); end
    step();
    s_valid = 1'b0;
    checks++;
    if (s_err !== 1'b1 || s_gpio !== 12'h005 || s_busy !== 12'h000) begin
      errors++;
      $display("[TB] FAIL oor_err: got err=%b gpio=%h busy=%h expected 1 005 000", s_err, s_gpio, s_busy);
    end
    step();
    checks++;
    if (s_err !== 1'b0) begin errors++; $display("[TB] FAIL oor_err_strobe: got %b expected 0", s_err); end
    s_valid = 1'b1;
    s_pin   = 4'd11;
    s_op    = SET_HIGH;
    step();
    s_valid = 1'b0;
    checks++;
    if (s_err !== 1'b0 || s_gpio !== 12'h805) begin
      errors++;
      $display("[TB] FAIL oor_inrange: got err=%b gpio=%h expected 0 805", s_err, s_gpio);
    end
    s_op = SET_LOW;
  endtask

  task automatic test_reset_mid_pulse();
    logic rdy;
    issue(1, PULSE, 20, rdy);
    issue(4, PULSE, 20, rdy);
    issue(6, PULSE, 20, rdy);
    checks++;
    if (busy !== 16'h0052 || gpio_out !== 16'h0057) begin
      errors++;
      $display("[TB] FAIL mid_setup: got busy=%h gpio=%h expected 0052 0057", busy, gpio_out);
    end
    reset_n = 1'b0;
    step();
    checks++;
    if (gpio_out !== 16'h0005 || busy !== 16'h0000 || done !== 16'h0000 || cmd_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got gpio=%h busy=%h done=%h err=%b expected 0005 0000 0000 0", gpio_out, busy, done, cmd_err);
    end
    checks++;
    if (s_gpio !== 12'h005) begin errors++; $display("[TB] FAIL mid_reset_small: got %h expected %h", s_gpio, 12'h005); end
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (gpio_out !== 16'h0005 || done !== 16'h0000 || busy !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL mid_after: got gpio=%h done=%h busy=%h expected 0005 0000 0000", gpio_out, done, busy);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_pin   = 4'd0;
    cmd_op    = SET_LOW;
    cmd_len   = 16'd0;
    s_valid   = 1'b0;
    s_pin     = 4'd0;
    s_op      = SET_LOW;
    s_len     = 16'd0;
    test_reset();
    test_pulse();
    test_back_to_back();
    test_set_abort();
    test_edge_cases();
    test_out_of_range();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
